// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register file: Status/Cause/EPC/BadVAddr exception state,
// free-running Count/Compare timer and the interrupt request it feeds.
module cp0_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [7:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        exc_en,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        int_req
);

    localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
    localparam logic [7:0] A_PRID     = {5'd15, 3'd0};
    localparam logic [7:0] A_CONFIG   = {5'd16, 3'd0};

    localparam logic [31:0] PRID_VAL   = 32'h0001_8000;
    localparam logic [31:0] CONFIG_VAL = 32'h8000_0000;

    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic        ti;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code_q;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;

    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic addr_exc;

    assign wr_count   = write_en && (addr == A_COUNT);
    assign wr_compare = write_en && (addr == A_COMPARE);
    assign wr_status  = write_en && (addr == A_STATUS);
    assign wr_cause   = write_en && (addr == A_CAUSE);
    assign wr_epc     = write_en && (addr == A_EPC);
    assign addr_exc   = (exc_code == 5'h04) || (exc_code == 5'h05);

    always_ff @(posedge clk) begin
        if (!rst) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            ti         <= 1'b0;
            ip_hw      <= '0;
            ip_sw      <= '0;
            exc_code_q <= '0;
            epc        <= '0;
            badvaddr   <= '0;
            count      <= '0;
            compare    <= '0;
            tick       <= 1'b0;
        end else begin
            // Timer path runs independently of exception/eret arbitration.
            if (wr_count) begin
                count <= write_data;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick)
                    count <= count + 32'd1;
            end

            if (wr_compare)
                compare <= write_data;

            if (wr_compare)
                ti <= 1'b0;
            else if (count == compare)
                ti <= 1'b1;

            ip_hw <= {hw_int[5] | ti, hw_int[4:0]};

            // Exception beats eret beats MTC0 for the architectural state.
            if (exc_en) begin
                exl        <= 1'b1;
                exc_code_q <= exc_code;
                if (!exl) begin
                    epc <= exc_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                    bd  <= exc_delay_slot;
                end
                if (addr_exc)
                    badvaddr <= exc_badvaddr;
            end else if (eret) begin
                exl <= 1'b0;
            end else begin
                if (wr_status) begin
                    im  <= write_data[15:8];
                    exl <= write_data[1];
                    ie  <= write_data[0];
                end
                if (wr_cause)
                    ip_sw <= write_data[9:8];
                if (wr_epc)
                    epc <= write_data;
            end
        end
    end

    assign status_o = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause_o  = {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code_q, 2'b0};
    assign epc_o    = epc;

    assign int_req = ie & ~exl & (|(im & cause_o[15:8]));

    always_comb begin
        read_data = '0;
        if (read_en) begin
            case (addr)
                A_BADVADDR: read_data = badvaddr;
                A_COUNT:    read_data = count;
                A_COMPARE:  read_data = compare;
                A_STATUS:   read_data = status_o;
                A_CAUSE:    read_data = cause_o;
                A_EPC:      read_data = epc;
                A_PRID:     read_data = PRID_VAL;
                A_CONFIG:   read_data = CONFIG_VAL;
                default:    read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed scenarios followed by randomized traffic, all checked against a
// word-level model of the CP0 registers kept in the bench.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en;
    logic        write_en;
    logic [7:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        exc_en;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic        int_req;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .exc_en(exc_en), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_delay_slot(exc_delay_slot), .exc_badvaddr(exc_badvaddr),
        .eret(eret), .hw_int(hw_int), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .int_req(int_req)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: whole architectural words plus the timer phase bit.
    logic [31:0] m_status, m_cause, m_epc, m_bva, m_count, m_compare;
    logic        m_tick;

    function automatic logic [31:0] m_read(input logic re, input logic [7:0] a);
        if (!re) return 32'h0;
        case (a)
            8'h40:   return m_bva;
            8'h48:   return m_count;
            8'h58:   return m_compare;
            8'h60:   return m_status;
            8'h68:   return m_cause;
            8'h70:   return m_epc;
            8'h78:   return 32'h0001_8000;
            8'h80:   return 32'h8000_0000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_int();
        return m_status[0] & ~m_status[1] & (|(m_status[15:8] & m_cause[15:8]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        read_en = 0; write_en = 0; addr = 0; write_data = 0;
        exc_en = 0; exc_code = 0; exc_pc = 0; exc_delay_slot = 0;
        exc_badvaddr = 0; eret = 0; hw_int = 0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        read_en = 1; addr = a;
        #1;
        chk(tag, read_data, exp);
        read_en = 0;
    endtask

    // One clock: check the combinational read, advance model and DUT, check outputs.
    task automatic step();
        logic [31:0] n_status, n_cause, n_epc, n_bva, n_count, n_compare;
        logic        n_tick, wr_cmp, wr_cnt;
        #1;
        chk("read_data", read_data, m_read(read_en, addr));
        wr_cmp = write_en && addr == 8'h58;
        wr_cnt = write_en && addr == 8'h48;
        if (!rst) begin
            n_status = 32'h0040_0000; n_cause = 0; n_epc = 0; n_bva = 0;
            n_count = 0; n_compare = 0; n_tick = 0;
        end else begin
            n_count   = wr_cnt ? write_data : (m_tick ? m_count + 32'd1 : m_count);
            n_tick    = wr_cnt ? 1'b0 : ~m_tick;
            n_compare = wr_cmp ? write_data : m_compare;
            n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_bva = m_bva;
            if (exc_en) begin
                n_status = m_status | 32'h2;
                n_cause[6:2] = exc_code;
                if (!m_status[1]) begin
                    n_epc = exc_pc - (exc_delay_slot ? 32'd4 : 32'd0);
                    n_cause[31] = exc_delay_slot;
                end
                if (exc_code inside {5'h04, 5'h05}) n_bva = exc_badvaddr;
            end else if (eret) begin
                n_status = m_status & ~32'h2;
            end else if (write_en) begin
                case (addr)
                    8'h60: n_status = 32'h0040_0000 | (write_data & 32'h0000_FF03);
                    8'h68: n_cause[9:8] = write_data[9:8];
                    8'h70: n_epc = write_data;
                    default: ;
                endcase
            end
            n_cause[30]    = wr_cmp ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_cause[30]);
            n_cause[15:10] = {hw_int[5] | m_cause[30], hw_int[4:0]};
        end
        @(posedge clk);
        #1;
        m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_bva = n_bva;
        m_count = n_count; m_compare = n_compare; m_tick = n_tick;
        chk("status_o", status_o, m_status);
        chk("cause_o", cause_o, m_cause);
        chk("epc_o", epc_o, m_epc);
        chk("int_req", {31'b0, int_req}, {31'b0, m_int()});
    endtask

    logic [7:0] alist [8] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h78, 8'h80};

    initial begin
        m_status = 0; m_cause = 0; m_epc = 0; m_bva = 0;
        m_count = 0; m_compare = 0; m_tick = 0;
        idle();
        rst = 0;
        // Reset with a pending exception and write that must be overridden.
        exc_en = 1; exc_code = 5'h04; exc_pc = 32'h1234_0000; exc_badvaddr = 32'hFFFF_0000;
        write_en = 1; addr = 8'h70; write_data = 32'h5555_5555;
        step();
        idle();
        step();
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_int", {31'b0, int_req}, 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        rst = 1;

        rd("prid", 8'h78, 32'h0001_8000);
        rd("status_rd", 8'h60, 32'h0040_0000);
        rd("unimpl_rd", 8'h50, 32'h0);
        rd("bva_rd", 8'h40, 32'h0);

        // Count wrap into a Compare match.
        write_en = 1; addr = 8'h48; write_data = 32'hFFFF_FFFE; step();
        addr = 8'h58; write_data = 32'h0; step();
        write_en = 0;
        repeat (4) step();
        rd("count_wrap", 8'h48, 32'h0);
        chk("ti_set", {31'b0, cause_o[30]}, 32'h1);
        step();
        chk("ip7_set", {31'b0, cause_o[15]}, 32'h1);
        write_en = 1; addr = 8'h60; write_data = 32'h0000_8001; step();
        write_en = 0;
        chk("int_on", {31'b0, int_req}, 32'h1);
        write_en = 1; addr = 8'h58; write_data = 32'h0000_1000; step();
        write_en = 0;
        chk("ti_clr", {31'b0, cause_o[30]}, 32'h0);
        step();
        chk("int_off", {31'b0, int_req}, 32'h0);

        // Address error in a delay slot.
        exc_en = 1; exc_code = 5'h04; exc_pc = 32'h8000_0100; exc_delay_slot = 1;
        exc_badvaddr = 32'h1234_5673; step();
        idle();
        chk("epc_ds", epc_o, 32'h8000_00FC);
        chk("bd", {31'b0, cause_o[31]}, 32'h1);
        chk("exl_set", {31'b0, status_o[1]}, 32'h1);
        chk("exccode4", {27'b0, cause_o[6:2]}, 32'h4);
        rd("bva_load", 8'h40, 32'h1234_5673);

        // Nested exception keeps EPC; eret then clears EXL.
        exc_en = 1; exc_code = 5'h08; exc_pc = 32'h9000_0000; exc_badvaddr = 32'hAAAA_AAAA; step();
        idle();
        chk("epc_hold", epc_o, 32'h8000_00FC);
        chk("exccode8", {27'b0, cause_o[6:2]}, 32'h8);
        rd("bva_hold", 8'h40, 32'h1234_5673);
        eret = 1; write_en = 1; addr = 8'h60; write_data = 32'h0000_0003; step();
        idle();
        chk("exl_clr", {31'b0, status_o[1]}, 32'h0);

        // Exception beats a same-cycle EPC write.
        exc_en = 1; exc_code = 5'h0D; exc_pc = 32'h8000_0200;
        write_en = 1; addr = 8'h70; write_data = 32'hDEAD_BEEF; step();
        idle();
        chk("epc_prio", epc_o, 32'h8000_0200);

        write_en = 1; addr = 8'h60; write_data = 32'hFFFF_FFFF; step();
        idle();
        chk("status_mask", status_o, 32'h0040_FF03);
        chk("int_exl", {31'b0, int_req}, 32'h0);
        eret = 1; step();
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 149) != 0);
            read_en        = $urandom_range(0, 3) != 0;
            addr           = ($urandom_range(0, 4) == 0) ? 8'($urandom) : alist[$urandom_range(0, 7)];
            write_en       = $urandom_range(0, 2) == 0;
            write_data     = $urandom;
            if (addr == 8'h48 || addr == 8'h58) write_data = $urandom_range(0, 15);
            exc_en         = $urandom_range(0, 9) == 0;
            exc_code       = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            exc_pc         = $urandom;
            exc_delay_slot = $urandom_range(0, 1) == 1;
            exc_badvaddr   = $urandom;
            eret           = $urandom_range(0, 9) == 0;
            hw_int         = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
